// File: rtl/tt_sweep_checker.sv
// Exhaustive 3-input sweep checker: drives {A,B,C}=0..7, holds each for HOLD_CYCLES,
// compares f1/f2 against EXP_F1/EXP_F2. Define TT_STOP_ON_ERR_EN to abort on first mismatch.
module tt_sweep_checker #(
    parameter int unsigned HOLD_CYCLES = 5,            // legal range 2..15
    parameter logic [7:0]  EXP_F1      = 8'b1001_0110,
    parameter logic [7:0]  EXP_F2      = 8'b1110_1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    input  logic       f1,
    input  logic       f2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [2:0] LAST_VEC  = 3'd7;

    logic [1:0] state_q, state_d;
    logic [2:0] index_q, index_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] err_q, err_d;
    logic [2:0] ff_q, ff_d;
    logic       pass_q, pass_d;

    logic       sample_hit;
    logic       mismatch;

    function automatic logic vec_mismatch(input logic [2:0] idx, input logic r1, input logic r2);
        return (r1 != EXP_F1[idx]) || (r2 != EXP_F2[idx]);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        hold_d     = hold_q;
        err_d      = err_q;
        ff_d       = ff_q;
        pass_d     = pass_q;
        sample_hit = 1'b0;
        mismatch   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRIVE;
                    index_d = 3'd0;
                    hold_d  = 4'd0;
                    err_d   = 4'd0;
                    ff_d    = 3'd0;
                    pass_d  = 1'b0;
                end
            end

            ST_DRIVE: begin
                sample_hit = (hold_q == HOLD_LAST);
                if (sample_hit) begin
                    mismatch = vec_mismatch(index_q, f1, f2);
                    if (mismatch) begin
                        err_d = sat_inc(err_q);
                        // err_q still zero means this is the first failing vector of the sweep
                        if (err_q == 4'd0) begin
                            ff_d = index_q;
                        end
                    end
`ifdef TT_STOP_ON_ERR_EN
                    if (mismatch) begin
                        state_d = ST_FINISH;
                        pass_d  = 1'b0;
                    end else if (index_q == LAST_VEC) begin
                        state_d = ST_FINISH;
                        pass_d  = (err_d == 4'd0);
                    end else begin
                        index_d = index_q + 3'd1;
                        hold_d  = 4'd0;
                    end
`else
                    if (index_q == LAST_VEC) begin
                        state_d = ST_FINISH;
                        pass_d  = (err_d == 4'd0);
                    end else begin
                        index_d = index_q + 3'd1;
                        hold_d  = 4'd0;
                    end
`endif
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            index_q <= 3'd0;
            hold_q  <= 4'd0;
            err_q   <= 4'd0;
            ff_q    <= 3'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            pass_q  <= pass_d;
        end
    end

    // The vector is the registered index itself, so it holds naturally outside DRIVE.
    assign A          = index_q[2];
    assign B          = index_q[1];
    assign C          = index_q[0];
    assign busy       = (state_q == ST_DRIVE);
    assign done       = (state_q == ST_FINISH);
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule
